// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO drain controller: default widths, buffer
// depths, the drain FSM state type and the read-room helper.
package fifo_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int FIFO_DEPTH     = 4;
  localparam int SKID_DEPTH     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } drain_state_e;

  // True when a read issued now still has a guaranteed landing slot.
  // A word popped this cycle frees its slot for the word that will
  // arrive one cycle after the read.
  function automatic logic read_room(
    input logic [1:0] occ,
    input logic       inflight,
    input logic       transfer,
    input int         depth
  );
    int free_slots;
    free_slots = depth - int'(occ) - int'(inflight) + int'(transfer);
    return (free_slots > 0);
  endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry ordered output buffer. Entry 0 is always the head; a push with
// simultaneous pop shifts the queue so order is preserved.
module stream_skid2
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] entry0;
  logic [DATA_W-1:0] entry1;
  logic              do_push;
  logic              do_pop;

  // Qualify push/pop so an empty pop or a full push can never corrupt state.
  always_comb begin
    do_pop  = pop && (occ != 2'd0);
    do_push = push && ((occ != 2'(SKID_DEPTH)) || do_pop);
  end

  // Buffer storage and occupancy; entries are cleared on reset so the head
  // reads as zero until the first word arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ    <= 2'd0;
      entry0 <= '0;
      entry1 <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == 2'd0) begin
            entry0 <= push_data;
          end else begin
            entry1 <= push_data;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: begin
          occ <= occ;
        end
      endcase
    end
  end

  assign head = entry0;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// Drains an upstream FIFO with one-cycle read latency into a 2-entry output
// buffer with valid/ready handshake. Reads are only issued when a slot is
// guaranteed for the returning word, so the buffer can never overflow.
module fifo_drain_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int SKID_DEPTH = fifo_pkg::SKID_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [15:0]       drain_count,
  output logic              err_rd_empty
);

  drain_state_e      state;
  drain_state_e      state_next;
  logic              inflight;
  logic              transfer;
  logic [1:0]        occ;
  logic [DATA_W-1:0] head;

  stream_skid2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (transfer),
    .occ       (occ),
    .head      (head)
  );

  assign m_valid = (occ != 2'd0);
  assign m_data  = head;
  assign busy    = (occ != 2'd0) || inflight;

  // Handshake and read issue; a read is only allowed with a free landing slot.
  always_comb begin
    transfer   = m_valid && m_ready;
    fifo_rd_en = (state == RUN) && !fifo_empty &&
                 read_room(occ, inflight, transfer, SKID_DEPTH);
  end

  // Drain FSM next state: resume wins over returning to idle in STOP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_next = STOP;
        end
      end
      STOP: begin
        if (enable) begin
          state_next = RUN;
        end else if ((occ == 2'd0) && !inflight) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A read this cycle means FIFO data is valid next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Saturating count of words handed downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drain_count <= 16'd0;
    end else if (transfer && (drain_count != 16'hFFFF)) begin
      drain_count <= drain_count + 16'd1;
    end
  end

  // Sticky flag for a read strobe presented to an empty FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_rd_empty <= 1'b0;
    end else if (fifo_rd_en && fifo_empty) begin
      err_rd_empty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Testbench for fifo_drain_ctrl: a queue-based upstream FIFO with one-cycle
// read latency, a recorder of reads/transfers, and per-scenario checks.
module tb_fifo_drain_ctrl;
  import fifo_pkg::*;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          busy;
  logic [15:0]   drain_count;
  logic          err_rd_empty;

  int tests_run    = 0;
  int tests_failed = 0;

  int            cycle;
  logic          rd_pend;
  int            rd_count;
  int            hold_viol;
  logic          prev_stall;
  logic [DW-1:0] prev_data;
  bit            rand_ready;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] out_q[$];
  int            rd_cycles[$];
  int            xfer_cycles[$];

  always #5 clk = ~clk;

  fifo_drain_ctrl #(.DATA_W(DW), .SKID_DEPTH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .busy         (busy),
    .drain_count  (drain_count),
    .err_rd_empty (err_rd_empty)
  );

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    sent_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: record outputs at the falling edge, then just after the
  // rising edge play the upstream FIFO (data one cycle after the strobe).
  task automatic tick();
    @(negedge clk);
    if (prev_stall && (!m_valid || (m_data !== prev_data))) hold_viol++;
    prev_stall = m_valid && !m_ready;
    prev_data  = m_data;
    rd_pend    = fifo_rd_en;
    if (fifo_rd_en) begin
      rd_count++;
      rd_cycles.push_back(cycle);
    end
    if (m_valid && m_ready) begin
      out_q.push_back(m_data);
      xfer_cycles.push_back(cycle);
    end
    @(posedge clk);
    #1;
    cycle++;
    if (rd_pend && (fifo_q.size() > 0)) fifo_rd_data = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    enable       = 1'b0;
    m_ready      = 1'b0;
    rand_ready   = 1'b0;
    fifo_q.delete();
    sent_q.delete();
    out_q.delete();
    rd_cycles.delete();
    xfer_cycles.delete();
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    rd_pend      = 1'b0;
    rd_count     = 0;
    hold_viol    = 0;
    prev_stall   = 1'b0;
    prev_data    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle = 0;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    enable       = 1'b1;
    m_ready      = 1'b1;
    fifo_empty   = 1'b0;
    fifo_rd_data = 8'h5A;
    #2;
    tests_run++;
    if (fifo_rd_en !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_rd_en: got %b expected 0", fifo_rd_en);
    end
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_m_valid: got %b expected 0", m_valid);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    tests_run++;
    if (m_data !== 8'h00) begin
      tests_failed++; $display("[TB] FAIL reset_m_data: got %0h expected 0", m_data);
    end
    tests_run++;
    if (drain_count !== 16'd0) begin
      tests_failed++; $display("[TB] FAIL reset_count: got %0d expected 0", drain_count);
    end
    tests_run++;
    if (err_rd_empty !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", err_rd_empty);
    end
  endtask

  task automatic test_basic_drain();
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    enable = 1'b1;
    for (int i = 0; i < 20 && out_q.size() < 4; i++) tick();
    repeat (3) tick();
    tests_run++;
    if (rd_count != 4) begin
      tests_failed++; $display("[TB] FAIL basic_reads: got %0d expected 4", rd_count);
    end
    tests_run++;
    if (out_q.size() != 4) begin
      tests_failed++; $display("[TB] FAIL basic_outputs: got %0d words expected 4", out_q.size());
    end else if (rd_cycles.size() == 4) begin
      tests_run++;
      if (rd_cycles[0] != 1) begin
        tests_failed++; $display("[TB] FAIL basic_first_read: cycle %0d expected 1", rd_cycles[0]);
      end
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if ((out_q[k] !== sent_q[k]) || (rd_cycles[k] != rd_cycles[0] + k) ||
            (xfer_cycles[k] != rd_cycles[0] + 2 + k)) begin
          tests_failed++;
          $display("[TB] FAIL basic_word%0d: data %0h rd@%0d out@%0d expected %0h rd@%0d out@%0d",
                   k, out_q[k], rd_cycles[k], xfer_cycles[k], sent_q[k], rd_cycles[0] + k,
                   rd_cycles[0] + 2 + k);
        end
      end
    end
    tests_run++;
    if (drain_count !== 16'd4) begin
      tests_failed++; $display("[TB] FAIL basic_count: got %0d expected 4", drain_count);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL basic_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(8'($urandom));
    enable = 1'b1;
    repeat (10) tick();
    tests_run++;
    if (rd_count != 2) begin
      tests_failed++; $display("[TB] FAIL stall_reads: got %0d expected 2", rd_count);
    end
    tests_run++;
    if ((m_valid !== 1'b1) || (m_data !== sent_q[0])) begin
      tests_failed++;
      $display("[TB] FAIL stall_head: valid %b data %0h expected 1 %0h", m_valid, m_data, sent_q[0]);
    end
    tests_run++;
    if (hold_viol != 0) begin
      tests_failed++; $display("[TB] FAIL stall_hold: got %0d changes expected 0", hold_viol);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 20 && out_q.size() < 4; i++) tick();
    repeat (2) tick();
    tests_run++;
    if ((out_q.size() != 4) || (out_q != sent_q)) begin
      tests_failed++; $display("[TB] FAIL stall_order: got %0d words (%p) expected %p", out_q.size(), out_q, sent_q);
    end
    tests_run++;
    if ((rd_count != 4) || (drain_count !== 16'd4)) begin
      tests_failed++; $display("[TB] FAIL stall_totals: reads %0d count %0d expected 4 4", rd_count, drain_count);
    end
  endtask

  task automatic test_stop();
    do_reset();
    m_ready = 1'b0;
    push_word(8'($urandom));
    enable = 1'b1;
    for (int i = 0; i < 10 && rd_count == 0; i++) tick();
    enable = 1'b0;
    repeat (3) tick();
    tests_run++;
    if (dut.state !== STOP) begin
      tests_failed++; $display("[TB] FAIL stop_state: got %0d expected %0d", dut.state, STOP);
    end
    tests_run++;
    if ((m_valid !== 1'b1) || (m_data !== sent_q[0]) || (rd_count != 1)) begin
      tests_failed++;
      $display("[TB] FAIL stop_present: valid %b data %0h reads %0d expected 1 %0h 1",
               m_valid, m_data, rd_count, sent_q[0]);
    end
    m_ready = 1'b1;
    repeat (3) tick();
    tests_run++;
    if ((dut.state !== IDLE) || (busy !== 1'b0) || (out_q.size() != 1)) begin
      tests_failed++;
      $display("[TB] FAIL stop_idle: state %0d busy %b words %0d expected %0d 0 1",
               dut.state, busy, out_q.size(), IDLE);
    end
    push_word(8'($urandom));
    push_word(8'($urandom));
    repeat (5) tick();
    tests_run++;
    if (rd_count != 1) begin
      tests_failed++; $display("[TB] FAIL stop_no_read: got %0d reads expected 1", rd_count);
    end
  endtask

  task automatic test_empty_fifo();
    bit saw_valid;
    saw_valid = 1'b0;
    do_reset();
    m_ready = 1'b1;
    enable  = 1'b1;
    repeat (20) begin
      tick();
      if (m_valid) saw_valid = 1'b1;
    end
    tests_run++;
    if ((rd_count != 0) || saw_valid) begin
      tests_failed++; $display("[TB] FAIL empty_quiet: reads %0d valid_seen %b expected 0 0", rd_count, saw_valid);
    end
    tests_run++;
    if (err_rd_empty !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL empty_err: got %b expected 0", err_rd_empty);
    end
  endtask

  task automatic test_reset_midflight();
    bit saw_valid;
    saw_valid = 1'b0;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'($urandom));
    enable = 1'b1;
    for (int i = 0; i < 20 && out_q.size() < 2; i++) tick();
    m_ready = 1'b0;
    repeat (4) tick();
    tests_run++;
    if ((m_valid !== 1'b1) || (drain_count !== 16'(out_q.size())) || (out_q.size() < 2)) begin
      tests_failed++;
      $display("[TB] FAIL midreset_pre: valid %b count %0d words %0d expected 1 and count==words>=2",
               m_valid, drain_count, out_q.size());
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({fifo_rd_en, m_valid, busy} !== 3'b000) begin
      tests_failed++; $display("[TB] FAIL midreset_flags: rd/valid/busy %b expected 000", {fifo_rd_en, m_valid, busy});
    end
    tests_run++;
    if ((m_data !== 8'h00) || (drain_count !== 16'd0)) begin
      tests_failed++; $display("[TB] FAIL midreset_clear: data %0h count %0d expected 0 0", m_data, drain_count);
    end
    enable = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_count = 0;
    prev_stall = 1'b0;
    repeat (6) begin
      tick();
      if (m_valid) saw_valid = 1'b1;
    end
    tests_run++;
    if (saw_valid || (rd_count != 0)) begin
      tests_failed++; $display("[TB] FAIL midreset_after: valid_seen %b reads %0d expected 0 0", saw_valid, rd_count);
    end
  endtask

  task automatic test_random_stream();
    logic [DW-1:0] words[$];
    int            num_bad;
    do_reset();
    for (int i = 0; i < 1000; i++) words.push_back(8'($urandom));
    rand_ready = 1'b1;
    m_ready    = 1'b1;
    enable     = 1'b1;
    for (int i = 0; i < 20000 && out_q.size() < 1000; i++) begin
      if ((words.size() > 0) && (fifo_q.size() < FIFO_DEPTH) && ($urandom_range(0, 3) != 0))
        push_word(words.pop_front());
      tick();
    end
    rand_ready = 1'b0;
    m_ready    = 1'b0;
    repeat (4) tick();
    num_bad = 0;
    tests_run++;
    if (out_q.size() != 1000) begin
      tests_failed++; $display("[TB] FAIL random_words: got %0d expected 1000", out_q.size());
    end else begin
      for (int k = 0; k < 1000; k++) if (out_q[k] !== sent_q[k]) num_bad++;
      tests_run++;
      if (num_bad != 0) begin
        tests_failed++; $display("[TB] FAIL random_order: got %0d wrong words expected 0", num_bad);
      end
    end
    tests_run++;
    if ((drain_count !== 16'd1000) || (rd_count != 1000)) begin
      tests_failed++; $display("[TB] FAIL random_count: count %0d reads %0d expected 1000 1000", drain_count, rd_count);
    end
    tests_run++;
    if ((err_rd_empty !== 1'b0) || (hold_viol != 0) || (busy !== 1'b0)) begin
      tests_failed++;
      $display("[TB] FAIL random_flags: err %b hold_changes %0d busy %b expected 0 0 0",
               err_rd_empty, hold_viol, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_stop();
    test_empty_fifo();
    test_reset_midflight();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
